// File: rtl/pi_output_stage_pkg.sv
// Shared constants for the PI output stage: default widths and FSM encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pi_output_stage_pkg;

  // Default word widths, kept in step with the pi_pipeline instantiations
  localparam int OUTPUT_WIDTH_DEF      = 32;
  localparam int OUTPUT_RANGE_BITS_DEF = 20;
  localparam int COUNT_WIDTH_DEF       = 16;

  // Output handshake FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/pi_output_stage_clamp.sv
// Clamps a PI result to the signed DAC range and optionally offset-binary encodes it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module pi_output_stage_clamp #(
  parameter int RANGE_BITS    = 20,
  parameter bit OFFSET_BINARY = 1'b0
) (
  input  logic [RANGE_BITS-1:0] value_in,
  input  logic                  overflow,
  input  logic                  underflow,
  output logic [RANGE_BITS-1:0] code_out,
  output logic                  clamped
);

  logic [RANGE_BITS-1:0] code_tc;

  // Saturate on pipeline flags (overflow wins if both are set), then encode
  always_comb begin
    code_tc = value_in;
    if (overflow) begin
      code_tc = {1'b0, {(RANGE_BITS-1){1'b1}}};
    end else if (underflow) begin
      code_tc = {1'b1, {(RANGE_BITS-1){1'b0}}};
    end
    clamped  = overflow | underflow;
    code_out = code_tc;
    if (OFFSET_BINARY) begin
      code_out = {~code_tc[RANGE_BITS-1], code_tc[RANGE_BITS-2:0]};
    end
  end

endmodule

// File: rtl/pi_output_stage.sv
// Captures PI results on a result_valid rising edge, clamps, commits integral (anti-windup), drives DAC.
// Latency: capture edge -> dac_data/dac_valid/integral_state/saturated visible next cycle.
// Backpressure: dac_valid held until dac_ready; a newer capture overwrites an unsent code (drop_count++).
module pi_output_stage
  import pi_output_stage_pkg::*;
#(
  parameter int OUTPUT_WIDTH      = OUTPUT_WIDTH_DEF,
  parameter int OUTPUT_RANGE_BITS = OUTPUT_RANGE_BITS_DEF,
  parameter bit OFFSET_BINARY     = 1'b0,
  parameter int COUNT_WIDTH       = COUNT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_L,
  input  logic                         enable,
  input  logic                         clear_integral,
  input  logic                         result_valid,
  input  logic [OUTPUT_WIDTH-1:0]      pi_result,
  input  logic [OUTPUT_WIDTH-1:0]      integral_result,
  input  logic                         overflow,
  input  logic                         underflow,
  output logic [OUTPUT_WIDTH-1:0]      integral_state,
  output logic [OUTPUT_RANGE_BITS-1:0] dac_data,
  output logic                         dac_valid,
  input  logic                         dac_ready,
  output logic                         saturated,
  output logic [COUNT_WIDTH-1:0]       sat_count,
  output logic [COUNT_WIDTH-1:0]       drop_count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  logic                         result_valid_q, result_valid_d;
  logic                         armed_q, armed_d;
  logic [0:0]                   state_q, state_d;
  logic [OUTPUT_RANGE_BITS-1:0] dac_data_q, dac_data_d;
  logic [OUTPUT_WIDTH-1:0]      integral_q, integral_d;
  logic                         saturated_q, saturated_d;
  logic [COUNT_WIDTH-1:0]       sat_count_q, sat_count_d;
  logic [COUNT_WIDTH-1:0]       drop_count_q, drop_count_d;

  logic [OUTPUT_RANGE_BITS-1:0] clamp_code;
  logic                         clamp_sat;
  logic                         capture;

  // Bits above the DAC range are discarded by truncation
  logic unused_pi_hi;
  assign unused_pi_hi = ^pi_result[OUTPUT_WIDTH-1:OUTPUT_RANGE_BITS];

  pi_output_stage_clamp #(
    .RANGE_BITS    (OUTPUT_RANGE_BITS),
    .OFFSET_BINARY (OFFSET_BINARY)
  ) u_clamp (
    .value_in  (pi_result[OUTPUT_RANGE_BITS-1:0]),
    .overflow  (overflow),
    .underflow (underflow),
    .code_out  (clamp_code),
    .clamped   (clamp_sat)
  );

  // armed_q blocks the first cycle after reset, so a result_valid level that
  // was already high across reset release is not mistaken for a new result.
  assign capture = enable & result_valid & ~result_valid_q & armed_q;

  // Next-state: edge tracking, captured result, anti-windup integral, counters, FSM
  always_comb begin
    result_valid_d = result_valid;
    armed_d        = 1'b1;
    state_d        = state_q;
    dac_data_d     = dac_data_q;
    integral_d     = integral_q;
    saturated_d    = saturated_q;
    sat_count_d    = sat_count_q;
    drop_count_d   = drop_count_q;

    if (capture) begin
      dac_data_d  = clamp_code;
      saturated_d = clamp_sat;
      if (!clamp_sat) begin
        integral_d = integral_result;
      end else if (sat_count_q != CNT_MAX) begin
        sat_count_d = sat_count_q + CNT_ONE;
      end
    end

    // Clearing overrides any commit in the same cycle
    if (clear_integral) begin
      integral_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        if (capture) begin
          // A capture with dac_ready high replaces an already-accepted code: no drop
          if (!dac_ready && (drop_count_q != CNT_MAX)) begin
            drop_count_d = drop_count_q + CNT_ONE;
          end
        end else if (dac_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous reset; dac_valid drops the moment rst_L falls
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      result_valid_q <= 1'b0;
      armed_q        <= 1'b0;
      state_q        <= ST_IDLE;
      dac_data_q     <= '0;
      integral_q     <= '0;
      saturated_q    <= 1'b0;
      sat_count_q    <= '0;
      drop_count_q   <= '0;
    end else begin
      result_valid_q <= result_valid_d;
      armed_q        <= armed_d;
      state_q        <= state_d;
      dac_data_q     <= dac_data_d;
      integral_q     <= integral_d;
      saturated_q    <= saturated_d;
      sat_count_q    <= sat_count_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign integral_state = integral_q;
  assign dac_data       = dac_data_q;
  assign dac_valid      = (state_q == ST_HOLD);
  assign saturated      = saturated_q;
  assign sat_count      = sat_count_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_pi_output_stage.sv
// Scoreboard bench for pi_output_stage: expected DAC transfers queued by stimulus, checked by a monitor.
// Latency: n/a (testbench).
// Backpressure: bench drives dac_ready directly.
module tb_pi_output_stage;

  localparam int W = 32;
  localparam int R = 20;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst_L = 1'b0;
  logic         enable = 1'b1;
  logic         clear_integral = 1'b0;
  logic         result_valid = 1'b0;
  logic [W-1:0] pi_result = '0;
  logic [W-1:0] integral_result = '0;
  logic         overflow = 1'b0;
  logic         underflow = 1'b0;
  logic         dac_ready = 1'b1;

  logic [W-1:0] integral_state;
  logic [R-1:0] dac_data;
  logic         dac_valid;
  logic         saturated;
  logic [C-1:0] sat_count;
  logic [C-1:0] drop_count;

  logic [R-1:0] ob_dac_data;
  logic [W-1:0] ob_unused_integral;
  logic         ob_unused_valid;
  logic         ob_unused_sat;
  logic [C-1:0] ob_unused_sat_count;
  logic [C-1:0] ob_unused_drop_count;

  typedef struct packed {
    logic [R-1:0] data;
    logic         sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   transfers = 0;

  always #5 clk = ~clk;

  pi_output_stage #(
    .OUTPUT_WIDTH(W), .OUTPUT_RANGE_BITS(R), .OFFSET_BINARY(1'b0), .COUNT_WIDTH(C)
  ) dut (
    .clk(clk), .rst_L(rst_L), .enable(enable), .clear_integral(clear_integral),
    .result_valid(result_valid), .pi_result(pi_result), .integral_result(integral_result),
    .overflow(overflow), .underflow(underflow), .integral_state(integral_state),
    .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .saturated(saturated), .sat_count(sat_count), .drop_count(drop_count)
  );

  pi_output_stage #(
    .OUTPUT_WIDTH(W), .OUTPUT_RANGE_BITS(R), .OFFSET_BINARY(1'b1), .COUNT_WIDTH(C)
  ) dut_ob (
    .clk(clk), .rst_L(rst_L), .enable(enable), .clear_integral(clear_integral),
    .result_valid(result_valid), .pi_result(pi_result), .integral_result(integral_result),
    .overflow(overflow), .underflow(underflow), .integral_state(ob_unused_integral),
    .dac_data(ob_dac_data), .dac_valid(ob_unused_valid), .dac_ready(dac_ready),
    .saturated(ob_unused_sat), .sat_count(ob_unused_sat_count), .drop_count(ob_unused_drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle result_valid pulse; returns just after the capturing edge
  task automatic capture(input logic [W-1:0] pi, input logic [W-1:0] integ,
                         input logic ov, input logic un);
    pi_result       = pi;
    integral_result = integ;
    overflow        = ov;
    underflow       = un;
    result_valid    = 1'b1;
    tick();
    result_valid    = 1'b0;
    overflow        = 1'b0;
    underflow       = 1'b0;
  endtask

  // Monitor: every accepted DAC transfer must match the oldest expected code
  always @(negedge clk) begin
    if (rst_L && dac_valid && dac_ready) begin
      transfers++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_transfer: got data 0x%0h, required no transfer", dac_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer_data", 32'(dac_data), 32'(mon_e.data));
        check("xfer_sat", 32'(saturated), 32'(mon_e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(dac_valid), 0);
    check("rst_data", 32'(dac_data), 0);
    check("rst_integral", integral_state, 0);
    check("rst_saturated", 32'(saturated), 0);
    check("rst_sat_count", 32'(sat_count), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    rst_L = 1'b1;
    tick();
    tick();

    // Plain result, ready high
    exp_q.push_back('{data: 20'h003E8, sat: 1'b0});
    capture(32'd1000, 32'd77, 1'b0, 1'b0);
    check("t1_valid", 32'(dac_valid), 1);
    check("t1_data", 32'(dac_data), 32'h003E8);
    check("t1_integral", integral_state, 32'd77);
    check("t1_saturated", 32'(saturated), 0);
    tick();
    check("t1_valid_fall", 32'(dac_valid), 0);

    // Preload integral to 5
    exp_q.push_back('{data: 20'h00005, sat: 1'b0});
    capture(32'd5, 32'd5, 1'b0, 1'b0);
    tick();
    check("pre_integral", integral_state, 32'd5);

    // Overflow: clamp high, integral held
    exp_q.push_back('{data: 20'h7FFFF, sat: 1'b1});
    capture(32'h0012_3456, 32'd900, 1'b1, 1'b0);
    check("t2_data", 32'(dac_data), 32'h7FFFF);
    check("t2_integral", integral_state, 32'd5);
    check("t2_saturated", 32'(saturated), 1);
    check("t2_sat_count", 32'(sat_count), 1);
    tick();

    // Underflow: two's complement and offset-binary
    exp_q.push_back('{data: 20'h80000, sat: 1'b1});
    capture(32'd0, 32'd11, 1'b0, 1'b1);
    check("t3_data", 32'(dac_data), 32'h80000);
    check("t3_ob_data", 32'(ob_dac_data), 32'h00000);
    check("t3_sat_count", 32'(sat_count), 2);
    check("t3_integral", integral_state, 32'd5);
    tick();

    // Both flags: overflow has priority
    exp_q.push_back('{data: 20'h7FFFF, sat: 1'b1});
    capture(32'd0, 32'd13, 1'b1, 1'b1);
    check("both_data", 32'(dac_data), 32'h7FFFF);
    check("both_sat_count", 32'(sat_count), 3);
    tick();

    // Negative in-range value truncates; offset-binary flips MSB
    exp_q.push_back('{data: 20'hFFFFD, sat: 1'b0});
    capture(32'hFFFF_FFFD, 32'd42, 1'b0, 1'b0);
    check("neg_ob_data", 32'(ob_dac_data), 32'h7FFFD);
    check("neg_integral", integral_state, 32'd42);
    tick();

    // Backpressure: 10 then 20, latest wins, one drop, one transfer
    dac_ready = 1'b0;
    capture(32'd10, 32'd30, 1'b0, 1'b0);
    tick();
    capture(32'd20, 32'd40, 1'b0, 1'b0);
    check("t4_valid", 32'(dac_valid), 1);
    check("t4_data", 32'(dac_data), 32'd20);
    check("t4_drop", 32'(drop_count), 1);
    check("t4_integral", integral_state, 32'd40);
    exp_q.push_back('{data: 20'd20, sat: 1'b0});
    dac_ready = 1'b1;
    tick();
    check("t4_valid_fall", 32'(dac_valid), 0);
    check("t4_transfers", transfers, 7);

    // Capture coinciding with an accepted transfer: no drop
    dac_ready = 1'b0;
    exp_q.push_back('{data: 20'd100, sat: 1'b0});
    capture(32'd100, 32'd50, 1'b0, 1'b0);
    tick();
    exp_q.push_back('{data: 20'd200, sat: 1'b0});
    dac_ready = 1'b1;
    capture(32'd200, 32'd60, 1'b0, 1'b0);
    check("bb_valid", 32'(dac_valid), 1);
    check("bb_data", 32'(dac_data), 32'd200);
    check("bb_drop", 32'(drop_count), 1);
    tick();
    check("bb_valid_fall", 32'(dac_valid), 0);

    // clear_integral beats a same-cycle commit
    clear_integral = 1'b1;
    exp_q.push_back('{data: 20'd7, sat: 1'b0});
    capture(32'd7, 32'd123, 1'b0, 1'b0);
    clear_integral = 1'b0;
    check("t5_integral", integral_state, 0);
    tick();

    // Disabled: edge ignored
    enable = 1'b0;
    capture(32'd9, 32'd99, 1'b0, 1'b0);
    check("dis_valid", 32'(dac_valid), 0);
    tick();
    check("dis_valid2", 32'(dac_valid), 0);
    check("dis_sat_count", 32'(sat_count), 3);
    check("dis_drop", 32'(drop_count), 1);
    check("dis_integral", integral_state, 0);
    enable = 1'b1;
    tick();

    // Reset mid-HOLD: pending code dropped without handshake
    dac_ready = 1'b0;
    capture(32'd55, 32'd66, 1'b0, 1'b0);
    check("t6_hold", 32'(dac_valid), 1);
    result_valid = 1'b1;
    #2;
    rst_L = 1'b0;
    #1;
    check("t6_async_valid", 32'(dac_valid), 0);
    check("t6_sat_count", 32'(sat_count), 0);
    check("t6_drop", 32'(drop_count), 0);
    check("t6_integral", integral_state, 0);
    @(posedge clk);
    #1;
    rst_L = 1'b1;
    dac_ready = 1'b1;
    tick();
    tick();
    check("t6_no_capture", 32'(dac_valid), 0);
    result_valid = 1'b0;
    tick();
    exp_q.push_back('{data: 20'd33, sat: 1'b0});
    capture(32'd33, 32'd44, 1'b0, 1'b0);
    check("t6_recapture", 32'(dac_valid), 1);
    tick();
    check("t6_valid_fall", 32'(dac_valid), 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
